// File: rtl/capture_sequencer.sv
// Frame sequencer for a periodic laser-triggered ADC capture: fire, fill, drain, hold off.
// Optional watchdog: define CAPTURE_TIMEOUT_EN to enable the no-progress timeout and FAULT state.
module capture_sequencer #(
  parameter int BEATS_IN       = 128,
  parameter int SAMPLES_OUT    = 1024,
  parameter int PERIOD_W       = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                s00_axis_aclk,
  input  logic                s00_axis_aresetn,
  input  logic                enable,
  input  logic                single_shot,
  input  logic [PERIOD_W-1:0] period,
  input  logic                adc_tvalid,
  input  logic                out_tvalid,
  input  logic                out_tready,
  input  logic                out_tlast,
  input  logic                clear_err,
  output logic                laser_trigger,
  output logic                capture_active,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                busy,
  output logic                timeout_err
);

  localparam int BEAT_W = $clog2(BEATS_IN + 1);
  localparam int SAMP_W = $clog2(SAMPLES_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_FILL, S_DRAIN, S_HOLDOFF, S_FAULT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [SAMP_W-1:0]   r_samp_cnt;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [15:0]         r_frame_count;
  logic                r_laser_trigger;
  logic                r_capture_active;
  logic                r_frame_done;
  logic                r_busy;

  logic                w_beat;
  logic                w_hs;
  logic                w_fill_done;
  logic                w_frame_end;
  logic [PERIOD_W-1:0] w_period_eff;
  logic                w_period_up;
  logic                w_wd_expire;
  logic                w_trigger_d;
  logic                w_active_d;
  logic                w_busy_d;

  assign w_beat       = (r_state == S_FILL) && adc_tvalid;
  assign w_hs         = (r_state == S_DRAIN) && out_tvalid && out_tready;
  assign w_fill_done  = w_beat && (r_beat_cnt == BEAT_W'(BEATS_IN - 1));
  assign w_frame_end  = w_hs && (out_tlast || (r_samp_cnt == SAMP_W'(SAMPLES_OUT - 1)));
  // A zero period behaves as one so the threshold below never underflows.
  assign w_period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign w_period_up  = (r_period_cnt >= (w_period_eff - PERIOD_W'(1)));

`ifdef CAPTURE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  logic            w_in_capture;
  logic            w_progress;

  assign w_in_capture = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign w_progress   = w_beat || w_hs;
  assign w_wd_expire  = w_in_capture && !w_progress && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wd_cnt      <= (!w_in_capture || w_progress) ? '0 : r_wd_cnt + WD_W'(1);
      r_timeout_err <= (w_next_state == S_FAULT);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_wd_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (enable || single_shot) w_next_state = S_FIRE;
      S_FIRE:    w_next_state = S_FILL;
      S_FILL:    if (w_fill_done)       w_next_state = S_DRAIN;
                 else if (w_wd_expire)  w_next_state = S_FAULT;
      S_DRAIN:   if (w_frame_end)       w_next_state = S_HOLDOFF;
                 else if (w_wd_expire)  w_next_state = S_FAULT;
      S_HOLDOFF: if (!enable)           w_next_state = S_IDLE;
                 else if (w_period_up)  w_next_state = S_FIRE;
      S_FAULT:   if (clear_err)         w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    w_trigger_d = (w_next_state == S_FIRE);
    w_active_d  = (w_next_state == S_FILL) || (w_next_state == S_DRAIN);
    w_busy_d    = (w_next_state != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state          <= S_IDLE;
      r_beat_cnt       <= '0;
      r_samp_cnt       <= '0;
      r_period_cnt     <= '0;
      r_frame_count    <= '0;
      r_laser_trigger  <= 1'b0;
      r_capture_active <= 1'b0;
      r_frame_done     <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_laser_trigger  <= w_trigger_d;
      r_capture_active <= w_active_d;
      r_frame_done     <= w_frame_end;
      r_busy           <= w_busy_d;
      r_frame_count    <= r_frame_count + 16'(w_frame_end);

      if (w_next_state == S_FIRE) begin
        r_beat_cnt   <= '0;
        r_samp_cnt   <= '0;
        r_period_cnt <= '0;
      end else begin
        if (w_beat) r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        if (w_hs)   r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
        if (r_period_cnt != '1) r_period_cnt <= r_period_cnt + PERIOD_W'(1);
      end
    end
  end

  assign laser_trigger  = r_laser_trigger;
  assign capture_active = r_capture_active;
  assign frame_done     = r_frame_done;
  assign frame_count    = r_frame_count;
  assign busy           = r_busy;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a table of single frames plus hand-written
// sequences for reset abort, periodic retrigger timing and the watchdog.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        single_shot = 1'b0;
  logic [23:0] period = 24'd5000;
  logic        adc_tvalid = 1'b0;
  logic        out_tvalid = 1'b0;
  logic        out_tready = 1'b0;
  logic        out_tlast = 1'b0;
  logic        clear_err = 1'b0;
  logic        laser_trigger;
  logic        capture_active;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;
  logic        timeout_err;

  capture_sequencer dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .enable           (enable),
    .single_shot      (single_shot),
    .period           (period),
    .adc_tvalid       (adc_tvalid),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready),
    .out_tlast        (out_tlast),
    .clear_err        (clear_err),
    .laser_trigger    (laser_trigger),
    .capture_active   (capture_active),
    .frame_done       (frame_done),
    .frame_count      (frame_count),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;
  int trig_c[8];
  int done_c[8];
  int n_t;
  int n_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_streams();
    adc_tvalid = 1'b0;
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    out_tlast  = 1'b0;
  endtask

  // Cycle 0 is the cycle in which laser_trigger is expected; exp_done is the
  // cycle frame_done is expected high, counted from cycle 0.
  typedef struct {
    string name;
    bit    start_en;
    bit    start_ss;
    int    en_drop;
    bit    adc_gap;
    int    out_mode;     // 0 continuous, 1 tready on even cycles, 2 tvalid on even cycles
    int    tlast_cycle;  // 0 = never
    int    ss_pulse;     // 0 = none
    int    exp_done;
  } frame_vec_t;

  frame_vec_t vecs[12];

  task automatic run_frame(input frame_vec_t v);
    int done_at = -1;
    int trig_n  = 0;
    int done_n  = 0;
    logic trig0 = 1'b0;
    logic act1  = 1'b0;
    logic act_done = 1'b1;
    logic busy_end = 1'b1;
    @(negedge clk);
    enable      = v.start_en;
    single_shot = v.start_ss;
    @(posedge clk);
    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      if (laser_trigger) trig_n++;
      if (c == 0) trig0 = laser_trigger;
      if (c == 1) act1 = capture_active;
      if (frame_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at  = c;
          act_done = capture_active;
        end
      end
      enable      = v.start_en && (c < v.en_drop);
      single_shot = (v.ss_pulse != 0) && (c == v.ss_pulse);
      adc_tvalid  = !v.adc_gap || (c % 2 == 1);
      out_tvalid  = (v.out_mode != 2) || (c % 2 == 0);
      out_tready  = (v.out_mode != 1) || (c % 2 == 0);
      out_tlast   = (v.tlast_cycle != 0) && (c == v.tlast_cycle);
      if (done_at >= 0 && c == done_at + 3) begin
        busy_end = busy;
        break;
      end
    end
    idle_streams();
    enable      = 1'b0;
    single_shot = 1'b0;
    exp_fc++;
    check({v.name, ".trigger_c0"}, 32'(trig0), 1);
    check({v.name, ".trigger_count"}, trig_n, 1);
    check({v.name, ".active_c1"}, 32'(act1), 1);
    check({v.name, ".done_cycle"}, done_at, v.exp_done);
    check({v.name, ".done_pulses"}, done_n, 1);
    check({v.name, ".active_at_done"}, 32'(act_done), 0);
    check({v.name, ".busy_after"}, 32'(busy_end), 0);
    check({v.name, ".frame_count"}, frame_count, 16'(exp_fc));
  endtask

  task automatic run_periodic(input logic [23:0] per, input int n_trig);
    int c = 0;
    n_t = 0;
    n_d = 0;
    for (int i = 0; i < 8; i++) begin
      trig_c[i] = -1;
      done_c[i] = -1;
    end
    period     = per;
    adc_tvalid = 1'b1;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    while (c < 20000) begin
      @(negedge clk);
      c++;
      if (laser_trigger) begin
        if (n_t < 8) trig_c[n_t] = c;
        n_t++;
      end
      if (frame_done) begin
        if (n_d < 8) done_c[n_d] = c;
        n_d++;
      end
      if (n_t >= n_trig) enable = 1'b0;
      if (n_t >= n_trig && !busy) break;
    end
    enable = 1'b0;
    idle_streams();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0]  = '{"basic",          1'b0, 1'b1, 0,   1'b0, 0, 0,    0,    1153};
    vecs[1]  = '{"tlast_512",      1'b0, 1'b1, 0,   1'b0, 0, 640,  0,    641};
    vecs[2]  = '{"adc_gap",        1'b0, 1'b1, 0,   1'b1, 0, 0,    0,    1280};
    vecs[3]  = '{"tlast_first",    1'b0, 1'b1, 0,   1'b0, 0, 129,  0,    130};
    vecs[4]  = '{"tlast_in_fill",  1'b0, 1'b1, 0,   1'b0, 0, 128,  0,    1153};
    vecs[5]  = '{"tlast_last",     1'b0, 1'b1, 0,   1'b0, 0, 1152, 0,    1153};
    vecs[6]  = '{"tready_gap",     1'b0, 1'b1, 0,   1'b0, 1, 0,    0,    2177};
    vecs[7]  = '{"tvalid_gap",     1'b0, 1'b1, 0,   1'b0, 2, 0,    0,    2177};
    vecs[8]  = '{"ss_in_fill",     1'b0, 1'b1, 0,   1'b0, 0, 0,    50,   1153};
    vecs[9]  = '{"ss_in_holdoff",  1'b0, 1'b1, 0,   1'b0, 0, 0,    1153, 1153};
    vecs[10] = '{"en_ss_drop_fill",1'b1, 1'b1, 100, 1'b0, 0, 0,    0,    1153};
    vecs[11] = '{"en_drop_drain",  1'b1, 1'b0, 600, 1'b0, 0, 0,    0,    1153};

    // Reset state, with start requests present during reset.
    single_shot = 1'b1;
    enable      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.laser_trigger", 32'(laser_trigger), 0);
    check("reset.capture_active", 32'(capture_active), 0);
    check("reset.frame_done", 32'(frame_done), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.timeout_err", 32'(timeout_err), 0);
    check("reset.frame_count", frame_count, 0);
    single_shot = 1'b0;
    enable      = 1'b0;
    rst_n       = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.busy", 32'(busy), 0);

    // Reset pulsed in DRAIN aborts the frame without counting it.
    single_shot = 1'b1;
    @(posedge clk);
    adc_tvalid = 1'b1;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      single_shot = 1'b0;
    end
    check("abort.busy_before", 32'(busy), 1);
    check("abort.active_before", 32'(capture_active), 1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 0);
    check("abort.active", 32'(capture_active), 0);
    check("abort.laser_trigger", 32'(laser_trigger), 0);
    check("abort.frame_done", 32'(frame_done), 0);
    check("abort.frame_count", frame_count, 16'(exp_fc));
    @(negedge clk);
    idle_streams();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort.busy_after", 32'(busy), 0);
    check("abort.no_retrigger", 32'(laser_trigger), 0);

    for (int i = 0; i < 12; i++) run_frame(vecs[i]);

    // Periodic capture: triggers exactly one period apart.
    run_periodic(24'd5000, 3);
    exp_fc += 3;
    check("per5000.triggers", n_t, 3);
    check("per5000.frames", n_d, 3);
    check("per5000.gap1", trig_c[1] - trig_c[0], 5000);
    check("per5000.gap2", trig_c[2] - trig_c[1], 5000);
    check("per5000.frame_count", frame_count, 16'(exp_fc));
    check("per5000.busy_after", 32'(busy), 0);

    // Period shorter than a frame: retrigger on the cycle after frame_done.
    run_periodic(24'd10, 3);
    exp_fc += 3;
    check("per10.triggers", n_t, 3);
    check("per10.frames", n_d, 3);
    check("per10.after_done1", trig_c[1] - done_c[0], 1);
    check("per10.after_done2", trig_c[2] - done_c[1], 1);
    check("per10.gap1", trig_c[1] - trig_c[0], 1154);
    check("per10.frame_count", frame_count, 16'(exp_fc));

    run_periodic(24'd0, 2);
    exp_fc += 2;
    check("per0.triggers", n_t, 2);
    check("per0.after_done", trig_c[1] - done_c[0], 1);
    check("per0.frame_count", frame_count, 16'(exp_fc));

    // Stalled ADC stream after the trigger.
    begin
      logic te_4096 = 1'b1;
      logic te_4097 = 1'b0;
      logic act_4097 = 1'b0;
      logic busy_4097 = 1'b0;
      idle_streams();
      @(negedge clk);
      single_shot = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= 4097; c++) begin
        @(negedge clk);
        single_shot = 1'b0;
        if (c == 4096) te_4096 = timeout_err;
        if (c == 4097) begin
          te_4097   = timeout_err;
          act_4097  = capture_active;
          busy_4097 = busy;
        end
      end
      check("stall.te_4096", 32'(te_4096), 0);
      check("stall.busy_4097", 32'(busy_4097), 1);
`ifdef CAPTURE_TIMEOUT_EN
      check("stall.te_4097", 32'(te_4097), 1);
      check("stall.active_4097", 32'(act_4097), 0);
      enable      = 1'b1;
      single_shot = 1'b1;
      repeat (5) begin
        @(negedge clk);
        check("fault.no_trigger", 32'(laser_trigger), 0);
      end
      enable      = 1'b0;
      single_shot = 1'b0;
      check("fault.busy", 32'(busy), 1);
      check("fault.te_held", 32'(timeout_err), 1);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("clear.te", 32'(timeout_err), 0);
      check("clear.busy", 32'(busy), 0);
`else
      check("stall.te_4097", 32'(te_4097), 0);
      check("stall.active_4097", 32'(act_4097), 1);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      @(negedge clk);
      check("stall.clear_ignored", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_fc = 0;
      @(negedge clk);
      check("stall.reset_busy", 32'(busy), 0);
      check("stall.reset_fc", frame_count, 16'(exp_fc));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
